// File: rtl/pwm_multi_gen.sv
// rtl/pwm_multi_gen.sv - multi-channel PWM with shared prescaled counter, edge/center modes and shadowed registers
// Optional polarity register enabled by `define PWM_POLARITY_EN.
module pwm_multi_gen #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);

  localparam logic [ADDR_W-1:0] ADDR_PERIOD   = ADDR_W'(CHANNELS);
  localparam logic [ADDR_W-1:0] ADDR_PRESCALE = ADDR_W'(CHANNELS + 1);
  localparam logic [ADDR_W-1:0] ADDR_CTRL     = ADDR_W'(CHANNELS + 2);

  logic [WIDTH-1:0]      duty_sh  [CHANNELS];
  logic [WIDTH-1:0]      duty_act [CHANNELS];
  logic [WIDTH-1:0]      duty_nxt [CHANNELS];
  logic [WIDTH-1:0]      period_sh, period_act, period_nxt;
  logic [PRESCALE_W-1:0] prescale_sh, prescale_act, prescale_nxt;
  logic                  mode_sh, mode_act, mode_nxt;
  logic                  force_upd;
  logic [CHANNELS-1:0]   pol_mask;

  logic [PRESCALE_W-1:0] pre_cnt;
  logic [WIDTH-1:0]      cnt, cnt_step;
  logic                  dir_down, dir_step;
  logic                  tick, at_end, boundary, load_act;
  logic [CHANNELS-1:0]   cmp;

  // Shadow values as they will be after this cycle's write; force_upd loads these directly.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) duty_nxt[i] = duty_sh[i];
    period_nxt   = period_sh;
    prescale_nxt = prescale_sh;
    mode_nxt     = mode_sh;
    force_upd    = 1'b0;
    if (wr_en) begin
      for (int i = 0; i < CHANNELS; i++)
        if (wr_addr == ADDR_W'(i)) duty_nxt[i] = wr_data;
      if (wr_addr == ADDR_PERIOD)   period_nxt   = wr_data;
      if (wr_addr == ADDR_PRESCALE) prescale_nxt = PRESCALE_W'(wr_data);
      if (wr_addr == ADDR_CTRL) begin
        mode_nxt  = wr_data[0];
        force_upd = wr_data[1];
      end
    end
  end

  assign tick     = (pre_cnt == prescale_act);
  assign boundary = en && tick && at_end && !force_upd;
  assign load_act = !en || force_upd || boundary;

  always_comb begin
    cnt_step = cnt;
    dir_step = dir_down;
    at_end   = 1'b0;
    if (!mode_act) begin
      at_end   = (cnt == period_act);
      cnt_step = at_end ? '0 : cnt + 1'b1;
    end else if (period_act == '0) begin
      at_end   = 1'b1;
      cnt_step = '0;
      dir_step = 1'b0;
    end else if (!dir_down) begin
      if (cnt == period_act) begin
        dir_step = 1'b1;
        cnt_step = cnt - 1'b1;
      end else begin
        cnt_step = cnt + 1'b1;
      end
    end else if (cnt == '0) begin
      at_end   = 1'b1;
      dir_step = 1'b0;
      cnt_step = WIDTH'(1);
    end else begin
      cnt_step = cnt - 1'b1;
    end
  end

  always_comb begin
    cmp = '0;
    for (int i = 0; i < CHANNELS; i++) cmp[i] = (cnt < duty_act[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) duty_sh[i] <= '0;
      period_sh   <= '0;
      prescale_sh <= '0;
      mode_sh     <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) duty_sh[i] <= duty_nxt[i];
      period_sh   <= period_nxt;
      prescale_sh <= prescale_nxt;
      mode_sh     <= mode_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) duty_act[i] <= '0;
      period_act   <= '0;
      prescale_act <= '0;
      mode_act     <= 1'b0;
    end else if (load_act) begin
      for (int i = 0; i < CHANNELS; i++) duty_act[i] <= force_upd ? duty_nxt[i] : duty_sh[i];
      period_act   <= force_upd ? period_nxt   : period_sh;
      prescale_act <= force_upd ? prescale_nxt : prescale_sh;
      mode_act     <= force_upd ? mode_nxt     : mode_sh;
    end
  end

`ifdef PWM_POLARITY_EN
  localparam logic [ADDR_W-1:0] ADDR_POL = ADDR_W'(CHANNELS + 3);
  logic [CHANNELS-1:0] pol_sh, pol_act;

  always_ff @(posedge clk) begin
    if (rst) begin
      pol_sh  <= '0;
      pol_act <= '0;
    end else begin
      if (wr_en && wr_addr == ADDR_POL) pol_sh <= CHANNELS'(wr_data);
      if (load_act) pol_act <= pol_sh;
    end
  end
  assign pol_mask = pol_act;
`else
  assign pol_mask = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      pre_cnt     <= '0;
      cnt         <= '0;
      dir_down    <= 1'b0;
      pwm_out     <= rst ? '0 : pol_mask;
      period_tick <= 1'b0;
    end else begin
      pwm_out     <= cmp ^ pol_mask;
      period_tick <= boundary;
      if (force_upd) begin
        pre_cnt  <= '0;
        cnt      <= '0;
        dir_down <= 1'b0;
      end else if (tick) begin
        pre_cnt <= '0;
        if (at_end) begin
          // A mode switch or a zero center period restarts the new period from 0.
          dir_down <= 1'b0;
          cnt      <= (mode_sh != mode_act || period_sh == '0) ? '0 : cnt_step;
        end else begin
          cnt      <= cnt_step;
          dir_down <= dir_step;
        end
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb/tb_pwm_multi_gen.sv - scoreboard bench for pwm_multi_gen against a tick/position reference model
module tb_pwm_multi_gen;

  typedef struct packed {
    logic [3:0] pwm;
    logic       tick;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] pwm_out;
  logic       period_tick;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  int   mon_cyc;
  logic en_cur;

  int m_duty_sh[4], m_duty_act[4], n_duty[4];
  int m_period_sh, m_period_act, n_period;
  int m_pre_sh, m_pre_act, n_pre;
  int m_mode_sh, m_mode_act, n_mode;
  int m_pol_sh, m_pol_act, n_pol;
  int m_pre, m_pos;
  logic [3:0] e_pwm;
  logic       e_tick;

  pwm_multi_gen dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .pwm_out(pwm_out), .period_tick(period_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counter value seen by the comparators: position along a ramp (edge) or triangle (center).
  function automatic int model_cnt();
    if (m_mode_act == 0) return m_pos;
    return (m_pos <= m_period_act) ? m_pos : 2 * m_period_act - m_pos;
  endfunction

  function automatic int end_pos();
    return (m_mode_act != 0) ? 2 * m_period_act : m_period_act;
  endfunction

  task automatic copy_act(input bit from_next);
    for (int i = 0; i < 4; i++) m_duty_act[i] = from_next ? n_duty[i] : m_duty_sh[i];
    m_period_act = from_next ? n_period : m_period_sh;
    m_pre_act    = from_next ? n_pre    : m_pre_sh;
    m_mode_act   = from_next ? n_mode   : m_mode_sh;
    m_pol_act    = m_pol_sh;
  endtask

  task automatic model_step(input logic r, input logic e, input logic we, input int a, input int d);
    bit force_u;
    int c;
    e_tick = 1'b0;
    e_pwm  = 4'b0;
    if (r) begin
      for (int i = 0; i < 4; i++) begin m_duty_sh[i] = 0; m_duty_act[i] = 0; end
      m_period_sh = 0; m_period_act = 0; m_pre_sh = 0; m_pre_act = 0;
      m_mode_sh = 0; m_mode_act = 0; m_pol_sh = 0; m_pol_act = 0;
      m_pre = 0; m_pos = 0;
      return;
    end
    for (int i = 0; i < 4; i++) n_duty[i] = m_duty_sh[i];
    n_period = m_period_sh; n_pre = m_pre_sh; n_mode = m_mode_sh; n_pol = m_pol_sh;
    force_u = 1'b0;
    if (we) begin
      if (a < 4) n_duty[a] = d;
      else if (a == 4) n_period = d;
      else if (a == 5) n_pre = d;
      else if (a == 6) begin n_mode = d & 1; force_u = ((d >> 1) & 1) != 0; end
`ifdef PWM_POLARITY_EN
      else if (a == 7) n_pol = d & 15;
`endif
    end
    if (!e) begin
      e_pwm = 4'(m_pol_act);
      copy_act(force_u);
      m_pre = 0;
      m_pos = 0;
    end else begin
      c = model_cnt();
      for (int i = 0; i < 4; i++) e_pwm[i] = (c < m_duty_act[i]) ^ m_pol_act[i];
      if (force_u) begin
        copy_act(1'b1);
        m_pre = 0;
        m_pos = 0;
      end else if (m_pre == m_pre_act) begin
        m_pre = 0;
        if (m_pos == end_pos()) begin
          e_tick = 1'b1;
          if (m_mode_sh != m_mode_act || m_mode_sh == 0 || m_period_sh == 0) m_pos = 0;
          else m_pos = 1;
          copy_act(1'b0);
        end else begin
          m_pos++;
        end
      end else begin
        m_pre++;
      end
    end
    for (int i = 0; i < 4; i++) m_duty_sh[i] = n_duty[i];
    m_period_sh = n_period; m_pre_sh = n_pre; m_mode_sh = n_mode; m_pol_sh = n_pol;
  endtask

  task automatic step(input logic r, input logic e, input logic we, input logic [2:0] a, input logic [7:0] d);
    exp_t x;
    @(negedge clk);
    #1;
    rst = r; en = e; wr_en = we; wr_addr = a; wr_data = d;
    model_step(r, e, we, int'(a), int'(d));
    x.pwm  = e_pwm;
    x.tick = e_tick;
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, en_cur, 1'b0, 3'd0, 8'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    step(1'b0, en_cur, 1'b1, a, d);
  endtask

  initial begin
    exp_t x;
    mon_cyc = 0;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        mon_cyc++;
        n_checks++;
        if (pwm_out !== x.pwm) begin
          n_fail++;
          $display("FAIL pwm_out cycle %0d: got %b expected %b", mon_cyc, pwm_out, x.pwm);
        end
        n_checks++;
        if (period_tick !== x.tick) begin
          n_fail++;
          $display("FAIL period_tick cycle %0d: got %b expected %b", mon_cyc, period_tick, x.tick);
        end
      end
    end
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic       r, we;
    logic [2:0] a;
    logic [7:0] d;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    en_cur = 1'b0;

    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    idle(3);

    // edge mode, four duty patterns
    wr(3'd4, 8'd9); wr(3'd0, 8'd3); wr(3'd1, 8'd0); wr(3'd2, 8'd10); wr(3'd3, 8'd5);
    wr(3'd5, 8'd0); wr(3'd6, 8'd0);
    en_cur = 1'b1;
    idle(35);

    // shadowed duty write mid-period, then a write landing on a boundary
    wr(3'd0, 8'd7);
    idle(25);
    for (int k = 0; k < 40 && !(m_pre == m_pre_act && m_pos == end_pos()); k++) idle(1);
    wr(3'd0, 8'd6);
    idle(25);

    // center mode
    en_cur = 1'b0;
    wr(3'd4, 8'd4); wr(3'd0, 8'd2); wr(3'd6, 8'd1);
    en_cur = 1'b1;
    idle(40);

    // prescaler and force_update
    en_cur = 1'b0;
    wr(3'd4, 8'd9); wr(3'd0, 8'd3); wr(3'd5, 8'd2); wr(3'd6, 8'd0);
    en_cur = 1'b1;
    idle(70);
    wr(3'd6, 8'd2);
    idle(40);
    wr(3'd5, 8'd0); wr(3'd6, 8'd2);
    idle(15);

    // polarity register write (ignored unless the option is built in)
    wr(3'd7, 8'd1); wr(3'd0, 8'd3);
    idle(30);

    for (int k = 0; k < 800; k++) begin
      r = ($urandom_range(0, 299) == 0);
      if (!en_cur) en_cur = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 79) == 0) en_cur = 1'b0;
      we = ($urandom_range(0, 5) == 0);
      a  = 3'($urandom_range(0, 7));
      if (a == 3'd6)      d = 8'($urandom_range(0, 3));
      else if (a == 3'd5) d = 8'($urandom_range(0, 2));
      else                d = 8'($urandom_range(0, 12));
      step(r, en_cur, we, a, d);
    end

    @(posedge clk);
    #4;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
